uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 93 +++++++++
 tb/tb_uart_rx_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between a UART receiver and the register block.
// Circular buffer with show-ahead head, a level counter and a sticky overrun flag.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int THRESH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic [DATA_W-1:0]        i_data,
  output logic                     o_ready,
  input  logic                     pop,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_thresh,
  output logic                     o_overrun,
  input  logic                     clr_overrun,
  input  logic                     flush
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic              overrun;

  logic pop_ok;
  logic push_ok;
  logic drop;

  assign o_empty   = (level == '0);
  assign o_full    = (level == LW'(DEPTH));
  assign o_ready   = !o_full;
  assign o_thresh  = (level >= LW'(THRESH));
  assign o_level   = level;
  assign o_overrun = overrun;
  assign o_data    = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a push into a full FIFO with pop is kept.
  always_comb begin
    pop_ok  = pop && !o_empty && !flush;
    push_ok = i_valid && (!o_full || (pop && !o_empty)) && !flush;
    drop    = i_valid && o_full && !pop && !flush;
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Set has priority over clear so a drop in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: fixed vector table, directed corner
// sequences and random traffic, all checked against a queue-based model.
module tb_uart_rx_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int THRESH = 8;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_valid = 1'b0;
  logic [DATA_W-1:0] i_data = '0;
  logic              o_ready;
  logic              pop = 1'b0;
  logic [DATA_W-1:0] o_data;
  logic              o_empty;
  logic              o_full;
  logic [LW-1:0]     o_level;
  logic              o_thresh;
  logic              o_overrun;
  logic              clr_overrun = 1'b0;
  logic              flush = 1'b0;

  uart_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
    .pop(pop), .o_data(o_data), .o_empty(o_empty), .o_full(o_full),
    .o_level(o_level), .o_thresh(o_thresh), .o_overrun(o_overrun),
    .clr_overrun(clr_overrun), .flush(flush)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] model_q [$];
  logic              model_ov = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec rules on a queue: flush empties; pop needs data; push needs room or a pop.
  task automatic model_step(input logic v, input logic [DATA_W-1:0] d, input logic p,
                            input logic f, input logic c);
    bit pop_acc, push_acc, dropped;
    pop_acc = 0; push_acc = 0; dropped = 0;
    if (f) begin
      model_q.delete();
    end else begin
      pop_acc  = p && (model_q.size() > 0);
      push_acc = v && ((model_q.size() < DEPTH) || pop_acc);
      dropped  = v && !push_acc;
      if (pop_acc)  void'(model_q.pop_front());
      if (push_acc) model_q.push_back(d);
    end
    if (dropped) model_ov = 1'b1;
    else if (c)  model_ov = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int lvl;
    lvl = model_q.size();
    chk({tag, ".level"},   32'(o_level),   32'(lvl));
    chk({tag, ".empty"},   32'(o_empty),   32'(lvl == 0));
    chk({tag, ".full"},    32'(o_full),    32'(lvl == DEPTH));
    chk({tag, ".ready"},   32'(o_ready),   32'(lvl != DEPTH));
    chk({tag, ".thresh"},  32'(o_thresh),  32'(lvl >= THRESH));
    chk({tag, ".overrun"}, 32'(o_overrun), 32'(model_ov));
    if (lvl > 0) chk({tag, ".data"}, 32'(o_data), 32'(model_q[0]));
  endtask

  task automatic cyc(input string tag, input logic v, input logic [DATA_W-1:0] d,
                     input logic p, input logic f, input logic c);
    i_valid = v; i_data = d; pop = p; flush = f; clr_overrun = c;
    @(posedge clk);
    #1;
    model_step(v, d, p, f, c);
    i_valid = 0; pop = 0; flush = 0; clr_overrun = 0;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_q.delete();
    model_ov = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  typedef struct {
    logic              v;
    logic [DATA_W-1:0] d;
    logic              p;
    logic              f;
    logic              c;
    int                lvl;
    logic              emp;
    logic              ov;
    logic [DATA_W-1:0] dat;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{1, 8'hA5, 0, 0, 0, 1, 0, 0, 8'hA5};
    vecs[1] = '{0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00};
    vecs[2] = '{0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00};
    vecs[3] = '{1, 8'h11, 1, 0, 0, 1, 0, 0, 8'h11};
    vecs[4] = '{1, 8'h22, 0, 0, 0, 2, 0, 0, 8'h11};
    vecs[5] = '{1, 8'h33, 1, 0, 0, 2, 0, 0, 8'h22};
    vecs[6] = '{1, 8'h44, 1, 1, 0, 0, 1, 0, 8'h00};
    vecs[7] = '{1, 8'h5A, 0, 0, 0, 1, 0, 0, 8'h5A};
    vecs[8] = '{0, 8'h00, 0, 0, 1, 1, 0, 0, 8'h5A};

    do_reset();
    #1;
    chk("reset.empty",   32'(o_empty),   32'd1);
    chk("reset.full",    32'(o_full),    32'd0);
    chk("reset.ready",   32'(o_ready),   32'd1);
    chk("reset.thresh",  32'(o_thresh),  32'd0);
    chk("reset.level",   32'(o_level),   32'd0);
    chk("reset.overrun", 32'(o_overrun), 32'd0);

    for (int i = 0; i < 9; i++) begin
      cyc($sformatf("vec%0d", i), vecs[i].v, vecs[i].d, vecs[i].p, vecs[i].f, vecs[i].c);
      chk($sformatf("vec%0d.lvl", i), 32'(o_level), 32'(vecs[i].lvl));
      chk($sformatf("vec%0d.emp", i), 32'(o_empty), 32'(vecs[i].emp));
      chk($sformatf("vec%0d.ov", i),  32'(o_overrun), 32'(vecs[i].ov));
      if (!vecs[i].emp) chk($sformatf("vec%0d.dat", i), 32'(o_data), 32'(vecs[i].dat));
    end

    // Fill to full, then pop all in order.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cyc("fill", 1, 8'(i), 0, 0, 0);
      chk("fill.thresh", 32'(o_thresh), 32'(i + 1 >= THRESH));
    end
    chk("fill.full",  32'(o_full),  32'd1);
    chk("fill.ready", 32'(o_ready), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain.data", 32'(o_data), 32'(i));
      cyc("drain", 0, 0, 1, 0, 0);
    end
    chk("drain.empty", 32'(o_empty), 32'd1);

    // Overrun set, clear, and set-beats-clear.
    for (int i = 0; i < DEPTH; i++) cyc("refill", 1, 8'(i), 0, 0, 0);
    cyc("ovr.drop", 1, 8'h77, 0, 0, 0);
    chk("ovr.set",   32'(o_overrun), 32'd1);
    chk("ovr.level", 32'(o_level),   32'(DEPTH));
    chk("ovr.head",  32'(o_data),    32'h00);
    cyc("ovr.clr", 0, 0, 0, 0, 1);
    chk("ovr.cleared", 32'(o_overrun), 32'd0);
    cyc("ovr.both", 1, 8'h78, 0, 0, 1);
    chk("ovr.setwins", 32'(o_overrun), 32'd1);

    // Push and pop together while full: no drop, pointers wrap.
    cyc("fullpp", 1, 8'h55, 1, 0, 0);
    chk("fullpp.level", 32'(o_level), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      chk("wrap.data", 32'(o_data), (i == DEPTH - 1) ? 32'h55 : 32'(i + 1));
      cyc("wrap", 0, 0, 1, 0, 0);
    end
    chk("wrap.empty", 32'(o_empty), 32'd1);

    // Flush overrides push/pop, overrun untouched; pop on empty ignored.
    for (int i = 0; i < 5; i++) cyc("pre5", 1, 8'(8'h80 + i), 0, 0, 0);
    cyc("flush", 1, 8'h99, 1, 1, 0);
    chk("flush.level", 32'(o_level),   32'd0);
    chk("flush.empty", 32'(o_empty),   32'd1);
    chk("flush.ovr",   32'(o_overrun), 32'd1);
    cyc("emptypop", 0, 0, 1, 0, 0);
    chk("emptypop.level", 32'(o_level), 32'd0);

    // Async reset mid-stream.
    for (int i = 0; i < 3; i++) cyc("pre3", 1, 8'(8'hC0 + i), 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("arst.empty", 32'(o_empty),   32'd1);
    chk("arst.level", 32'(o_level),   32'd0);
    chk("arst.ovr",   32'(o_overrun), 32'd0);
    model_q.delete();
    model_ov = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    cyc("post", 1, 8'h3C, 0, 0, 0);
    chk("post.data", 32'(o_data), 32'h3C);
    cyc("post.pop", 0, 0, 1, 0, 0);

    // Random traffic, alternating push-heavy and pop-heavy phases.
    for (int i = 0; i < 1500; i++) begin
      logic v, p, f, c;
      bit fill_phase;
      fill_phase = ((i / 100) % 2) == 0;
      v = fill_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      p = fill_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 63) == 0);
      c = ($urandom_range(0, 15) == 0);
      cyc("rand", v, 8'($urandom), p, f, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
